// File: rtl/board_write_sequencer.sv
// Sole writer of the 64x4 board RAM: loads the start position, then commits
// each accepted move as a destination write followed by a source clear.
module board_write_sequencer #(
    parameter bit PROMOTE_PAWNS = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [255:0] board_input,
    input  logic         new_game,
    input  logic         move_valid,
    output logic         move_ready,
    input  logic [5:0]   move_from,
    input  logic [5:0]   move_to,
    input  logic [3:0]   move_piece,
    output logic [5:0]   board_out_addr,
    output logic [3:0]   board_out_piece,
    output logic         board_change_enable,
    output logic [3:0]   captured_piece,
    output logic         init_done,
    output logic         move_done,
    output logic         move_err
);

    typedef enum logic [2:0] {INIT, IDLE, WR_DST, WR_SRC, DONE} state_t;

    state_t     state, state_n;
    logic [5:0] cnt, cnt_n;
    logic [5:0] from_q, from_n;
    logic [5:0] to_q, to_n;
    logic [3:0] piece_q, piece_n;
    logic       err_q, err_n;
    logic [5:0] addr_n;
    logic [3:0] wdata_n;
    logic       en_n;
    logic [3:0] captured_n;
    logic       init_done_n;
    logic       move_done_n;
    logic       move_err_n;
    logic       promote;

    function automatic logic [3:0] start_piece(input logic [5:0] sq);
        logic [2:0] back;
        case (sq[2:0])
            3'd0, 3'd7: back = 3'b100;
            3'd1, 3'd6: back = 3'b010;
            3'd2, 3'd5: back = 3'b011;
            3'd3:       back = 3'b101;
            default:    back = 3'b110;
        endcase
        case (sq[5:3])
            3'd0:    start_piece = {1'b1, back};
            3'd1:    start_piece = 4'b1001;
            3'd6:    start_piece = 4'b0001;
            3'd7:    start_piece = {1'b0, back};
            default: start_piece = 4'b0000;
        endcase
    endfunction

    assign move_ready = (state == IDLE) && !new_game;

    // A pawn landing on the far rank for its own colour becomes a queen.
    assign promote = PROMOTE_PAWNS && (piece_q[2:0] == 3'b001) &&
                     ((!piece_q[3] && (to_q[5:3] == 3'd0)) ||
                      ( piece_q[3] && (to_q[5:3] == 3'd7)));

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        from_n      = from_q;
        to_n        = to_q;
        piece_n     = piece_q;
        err_n       = err_q;
        en_n        = 1'b0;
        addr_n      = board_out_addr;
        wdata_n     = board_out_piece;
        captured_n  = captured_piece;
        init_done_n = init_done;
        move_done_n = 1'b0;
        move_err_n  = 1'b0;
        case (state)
            INIT: begin
                en_n    = 1'b1;
                addr_n  = cnt;
                wdata_n = start_piece(cnt);
                cnt_n   = cnt + 6'd1;
                if (cnt == 6'd63) begin
                    state_n     = IDLE;
                    init_done_n = 1'b1;
                end
            end
            IDLE: begin
                if (new_game) begin
                    init_done_n = 1'b0;
                    cnt_n       = '0;
                    state_n     = INIT;
                end else if (move_valid) begin
                    from_n     = move_from;
                    to_n       = move_to;
                    piece_n    = move_piece;
                    captured_n = board_input[{move_to, 2'b00} +: 4];
                    if ((move_from == move_to) || (move_piece[2:0] == 3'b000)) begin
                        err_n   = 1'b1;
                        state_n = DONE;
                    end else begin
                        err_n   = 1'b0;
                        state_n = WR_DST;
                    end
                end
            end
            WR_DST: begin
                en_n    = 1'b1;
                addr_n  = to_q;
                wdata_n = promote ? {piece_q[3], 3'b101} : piece_q;
                state_n = WR_SRC;
            end
            WR_SRC: begin
                en_n    = 1'b1;
                addr_n  = from_q;
                wdata_n = '0;
                state_n = DONE;
            end
            DONE: begin
                move_done_n = !err_q;
                move_err_n  = err_q;
                state_n     = IDLE;
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state               <= INIT;
            cnt                 <= '0;
            from_q              <= '0;
            to_q                <= '0;
            piece_q             <= '0;
            err_q               <= 1'b0;
            board_change_enable <= 1'b0;
            board_out_addr      <= '0;
            board_out_piece     <= '0;
            captured_piece      <= '0;
            init_done           <= 1'b0;
            move_done           <= 1'b0;
            move_err            <= 1'b0;
        end else begin
            state               <= state_n;
            cnt                 <= cnt_n;
            from_q              <= from_n;
            to_q                <= to_n;
            piece_q             <= piece_n;
            err_q               <= err_n;
            board_change_enable <= en_n;
            board_out_addr      <= addr_n;
            board_out_piece     <= wdata_n;
            captured_piece      <= captured_n;
            init_done           <= init_done_n;
            move_done           <= move_done_n;
            move_err            <= move_err_n;
        end
    end

endmodule

// File: tb/tb_board_write_sequencer.sv
// Directed plus random move bench for board_write_sequencer with a board RAM
// and a chess-level reference model of the expected writes.
module tb_board_write_sequencer;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [255:0] board_input;
    logic         new_game, move_valid;
    logic [5:0]   move_from, move_to;
    logic [3:0]   move_piece;
    logic         move_ready, board_change_enable, init_done, move_done, move_err;
    logic [5:0]   board_out_addr;
    logic [3:0]   board_out_piece, captured_piece;

    logic         p0_ready, p0_en, p0_init_done, p0_done, p0_err;
    logic [5:0]   p0_addr;
    logic [3:0]   p0_piece, p0_cap;

    int errors = 0;
    int checks = 0;

    logic [3:0] ram [64];
    logic [3:0] model [64];
    logic [3:0] start_pos [64];

    always #5 CLK = ~CLK;

    board_write_sequencer #(.PROMOTE_PAWNS(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .board_input(board_input), .new_game(new_game),
        .move_valid(move_valid), .move_ready(move_ready), .move_from(move_from),
        .move_to(move_to), .move_piece(move_piece), .board_out_addr(board_out_addr),
        .board_out_piece(board_out_piece), .board_change_enable(board_change_enable),
        .captured_piece(captured_piece), .init_done(init_done), .move_done(move_done),
        .move_err(move_err)
    );

    board_write_sequencer #(.PROMOTE_PAWNS(1'b0)) dut_nopromo (
        .CLK(CLK), .RESET(RESET), .board_input(board_input), .new_game(new_game),
        .move_valid(move_valid), .move_ready(p0_ready), .move_from(move_from),
        .move_to(move_to), .move_piece(move_piece), .board_out_addr(p0_addr),
        .board_out_piece(p0_piece), .board_change_enable(p0_en),
        .captured_piece(p0_cap), .init_done(p0_init_done), .move_done(p0_done),
        .move_err(p0_err)
    );

    always @(posedge CLK) if (board_change_enable) ram[board_out_addr] <= board_out_piece;

    always_comb begin
        board_input = '0;
        for (int i = 0; i < 64; i++) board_input[i*4 +: 4] = ram[i];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] code_of(input byte c);
        case (c)
            "p": code_of = 3'd1;
            "n": code_of = 3'd2;
            "b": code_of = 3'd3;
            "r": code_of = 3'd4;
            "q": code_of = 3'd5;
            "k": code_of = 3'd6;
            default: code_of = 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] placed(input logic [3:0] pc, input int to, input bit promo);
        bit far_rank;
        far_rank = pc[3] ? (to / 8 == 7) : (to / 8 == 0);
        if (promo && pc[2:0] == 3'd1 && far_rank) placed = {pc[3], 3'd5};
        else placed = pc;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ram_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== model[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic check_init();
        int w = 0;
        while (!board_change_enable && w < 8) begin step(); w++; end
        chk("init_start", board_change_enable, 1);
        for (int i = 0; i < 64; i++) begin
            chk("init_en", board_change_enable, 1);
            chk("init_addr", board_out_addr, i);
            chk("init_piece", board_out_piece, start_pos[i]);
            chk("init_done_flag", init_done, (i == 63) ? 1 : 0);
            if (i < 63) chk("init_ready", move_ready, 0);
            step();
        end
        chk("init_idle_en", board_change_enable, 0);
        chk("init_idle_ready", move_ready, 1);
        for (int i = 0; i < 64; i++) model[i] = start_pos[i];
        ram_check("ram_after_init");
    endtask

    task automatic do_move(input int from, input int to, input logic [3:0] pc);
        int w = 0;
        bit legal;
        logic [3:0] cap;
        while (!move_ready && w < 8) begin step(); w++; end
        chk("ready_before_move", move_ready, 1);
        legal = (from != to) && (pc[2:0] != 3'd0);
        cap = model[to];
        move_from = from[5:0]; move_to = to[5:0]; move_piece = pc; move_valid = 1'b1;
        step();
        move_valid = 1'b0;
        move_from = 6'($urandom); move_to = 6'($urandom); move_piece = 4'($urandom);
        chk("accept_en", board_change_enable, 0);
        chk("captured", captured_piece, cap);
        if (legal) begin
            step();
            chk("dst_en", board_change_enable, 1);
            chk("dst_addr", board_out_addr, to);
            chk("dst_piece", board_out_piece, placed(pc, to, 1));
            chk("dst_piece_nopromo", p0_piece, placed(pc, to, 0));
            step();
            chk("src_en", board_change_enable, 1);
            chk("src_addr", board_out_addr, from);
            chk("src_piece", board_out_piece, 0);
            step();
            chk("done_pulse", move_done, 1);
            chk("done_err", move_err, 0);
            chk("done_en", board_change_enable, 0);
            chk("done_ready", move_ready, 1);
            model[to] = placed(pc, to, 1);
            model[from] = 4'd0;
        end else begin
            step();
            chk("err_pulse", move_err, 1);
            chk("err_done", move_done, 0);
            chk("err_en", board_change_enable, 0);
            step();
            chk("err_single", move_err, 0);
            chk("err_en2", board_change_enable, 0);
            chk("err_ready", move_ready, 1);
        end
        ram_check("ram_after_move");
    endtask

    initial begin
        string back;
        int w;
        back = "rnbqkbnr";
        for (int c = 0; c < 8; c++) begin
            start_pos[c]      = {1'b1, code_of(back[c])};
            start_pos[8 + c]  = {1'b1, code_of("p")};
            start_pos[48 + c] = {1'b0, code_of("p")};
            start_pos[56 + c] = {1'b0, code_of(back[c])};
            for (int r = 2; r < 6; r++) start_pos[r*8 + c] = 4'd0;
        end

        RESET = 1'b1; new_game = 1'b0; move_valid = 1'b0;
        move_from = '0; move_to = '0; move_piece = '0;
        step(); step();
        chk("rst_en", board_change_enable, 0);
        chk("rst_addr", board_out_addr, 0);
        chk("rst_piece", board_out_piece, 0);
        chk("rst_cap", captured_piece, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_done", move_done, 0);
        chk("rst_err", move_err, 0);
        chk("rst_ready", move_ready, 0);
        RESET = 1'b0;
        check_init();
        chk("start_a8", ram[0], 4'b1100);
        chk("start_e8", ram[4], 4'b1110);
        chk("start_a7", ram[8], 4'b1001);
        chk("start_e2", ram[52], 4'b0001);
        chk("start_e1", ram[60], 4'b0110);

        do_move(52, 36, 4'b0001);
        chk("e4_pawn", ram[36], 4'b0001);
        chk("e2_empty", ram[52], 4'b0000);
        do_move(12, 4, 4'b0001);
        chk("white_promo", ram[4], 4'b0101);
        do_move(52, 60, 4'b1001);
        chk("black_promo", ram[60], 4'b1101);
        do_move(11, 27, 4'b1001);
        do_move(36, 27, 4'b0001);
        chk("capture_piece", captured_piece, 4'b1001);
        do_move(20, 20, 4'b0001);
        do_move(30, 40, 4'b0000);

        for (int k = 0; k < 24; k++) begin
            int f, t;
            logic [3:0] pc;
            f = $urandom_range(0, 63);
            t = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) pc = 4'd0;
            else pc = {1'($urandom_range(0, 1)), 3'($urandom_range(1, 6))};
            do_move(f, t, pc);
        end

        RESET = 1'b1; step(); RESET = 1'b0;
        w = 0;
        while (!(board_change_enable && board_out_addr == 6'd30) && w < 80) begin step(); w++; end
        chk("reach_write30", board_out_addr, 30);
        RESET = 1'b1; step();
        chk("rst30_en", board_change_enable, 0);
        chk("rst30_addr", board_out_addr, 0);
        chk("rst30_init_done", init_done, 0);
        RESET = 1'b0;
        check_init();

        move_from = 6'd51; move_to = 6'd35; move_piece = 4'b0001; move_valid = 1'b1;
        step();
        move_valid = 1'b0;
        step();
        chk("midmove_dst_en", board_change_enable, 1);
        chk("midmove_dst_addr", board_out_addr, 35);
        RESET = 1'b1; step();
        chk("midmove_rst_en", board_change_enable, 0);
        chk("midmove_rst_done", move_done, 0);
        RESET = 1'b0;
        check_init();

        new_game = 1'b1; move_valid = 1'b1;
        move_from = 6'd52; move_to = 6'd36; move_piece = 4'b0001;
        #1;
        chk("ng_ready", move_ready, 0);
        step();
        new_game = 1'b0; move_valid = 1'b0;
        chk("ng_init_done", init_done, 0);
        chk("ng_en", board_change_enable, 0);
        check_init();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
